// File: rtl/cell_op_pipeline.sv
// rtl/cell_op_pipeline.sv - two-stage saturating per-channel cell processor with valid/ready stream.
// Define SAT_FLAG_EN to add the per-channel sat_flag output.
module cell_op_pipeline #(
  parameter int CHANNEL_WIDTH = 8,
  parameter int CHANNEL_NUM   = 3,
  parameter int CELL_N        = 3,
  parameter int OPCODE_WIDTH  = 4
) (
  input  logic                                                   clk,
  input  logic                                                   rst,
  input  logic                                                   in_valid,
  output logic                                                   in_ready,
  input  logic [OPCODE_WIDTH-1:0]                                opcode,
  input  logic [CHANNEL_WIDTH*CHANNEL_NUM*CELL_N*CELL_N-1:0]     cell_a,
  input  logic [CHANNEL_WIDTH*CHANNEL_NUM*CELL_N*CELL_N-1:0]     cell_b,
  input  logic [CHANNEL_WIDTH*CHANNEL_NUM-1:0]                   user_input,
  output logic                                                   out_valid,
  input  logic                                                   out_ready,
  output logic [CHANNEL_WIDTH*CHANNEL_NUM-1:0]                   result,
  output logic                                                   bad_op
`ifdef SAT_FLAG_EN
  ,
  output logic [CHANNEL_NUM-1:0]                                 sat_flag
`endif
);

  localparam int CW   = CHANNEL_WIDTH;
  localparam int PW   = CHANNEL_WIDTH * CHANNEL_NUM;
  localparam int NPIX = CELL_N * CELL_N;
  localparam int CTR  = (NPIX - 1) / 2;
  localparam int SW   = CHANNEL_WIDTH + $clog2(NPIX);
  localparam logic [CW-1:0] MAXV = {CW{1'b1}};

  localparam logic [OPCODE_WIDTH-1:0] OP_ADD   = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI  = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB   = OPCODE_WIDTH'(2);
  localparam logic [OPCODE_WIDTH-1:0] OP_SUBI  = OPCODE_WIDTH'(3);
  localparam logic [OPCODE_WIDTH-1:0] OP_MULT  = OPCODE_WIDTH'(4);
  localparam logic [OPCODE_WIDTH-1:0] OP_MULTI = OPCODE_WIDTH'(5);
  localparam logic [OPCODE_WIDTH-1:0] OP_DIV2  = OPCODE_WIDTH'(6);
  localparam logic [OPCODE_WIDTH-1:0] OP_INV   = OPCODE_WIDTH'(7);
  localparam logic [OPCODE_WIDTH-1:0] OP_AND   = OPCODE_WIDTH'(8);
  localparam logic [OPCODE_WIDTH-1:0] OP_OR    = OPCODE_WIDTH'(9);
  localparam logic [OPCODE_WIDTH-1:0] OP_NOR   = OPCODE_WIDTH'(10);
  localparam logic [OPCODE_WIDTH-1:0] OP_AVG   = OPCODE_WIDTH'(11);

  logic                      s1Full;
  logic                      s1Moves;
  logic [OPCODE_WIDTH-1:0]   s1Op;
  logic [PW-1:0]             s1A;
  logic [PW-1:0]             s1B;
  logic [PW-1:0]             s1User;
  logic [CHANNEL_NUM*SW-1:0] s1Sum;
  logic [CHANNEL_NUM*SW-1:0] sumNext;
  logic [SW-1:0]             acc;
  logic [PW-1:0]             resNext;
  logic                      badNext;
  logic                      immForm;
  logic [CW-1:0]             chA;
  logic [CW-1:0]             chB;
  logic [CW-1:0]             chU;
  logic [CW-1:0]             opnd;
  logic [CW:0]               sum;
  logic [2*CW-1:0]           prod;
  logic                      unusedCellB;
`ifdef SAT_FLAG_EN
  logic [CHANNEL_NUM-1:0]    satNext;
`endif

  // Only the centre pixel of cell B is ever an operand.
  assign unusedCellB = ^cell_b;

  assign s1Moves  = !out_valid || out_ready;
  assign in_ready = !s1Full || s1Moves;

  // Channel sums over the whole A cell, registered in S1 so S2 only divides.
  always_comb begin
    sumNext = '0;
    acc     = '0;
    for (int c = 0; c < CHANNEL_NUM; c++) begin
      acc = '0;
      for (int k = 0; k < NPIX; k++) begin
        acc = acc + SW'(cell_a[k*PW + c*CW +: CW]);
      end
      sumNext[c*SW +: SW] = acc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1Full <= 1'b0;
      s1Op   <= '0;
      s1A    <= '0;
      s1B    <= '0;
      s1User <= '0;
      s1Sum  <= '0;
    end else if (in_ready) begin
      s1Full <= in_valid;
      if (in_valid) begin
        s1Op   <= opcode;
        s1A    <= cell_a[CTR*PW +: PW];
        s1B    <= cell_b[CTR*PW +: PW];
        s1User <= user_input;
        s1Sum  <= sumNext;
      end
    end
  end

  always_comb begin
    resNext = '0;
    badNext = 1'b0;
    chA     = '0;
    chB     = '0;
    chU     = '0;
    opnd    = '0;
    sum     = '0;
    prod    = '0;
`ifdef SAT_FLAG_EN
    satNext = '0;
`endif
    immForm = (s1Op == OP_ADDI) || (s1Op == OP_SUBI) || (s1Op == OP_MULTI);
    for (int c = 0; c < CHANNEL_NUM; c++) begin
      chA  = s1A[c*CW +: CW];
      chB  = s1B[c*CW +: CW];
      chU  = s1User[c*CW +: CW];
      opnd = immForm ? chU : chB;
      sum  = {1'b0, chA} + {1'b0, opnd};
      prod = {{CW{1'b0}}, chA} * {{CW{1'b0}}, opnd};
      case (s1Op)
        OP_ADD, OP_ADDI: begin
          resNext[c*CW +: CW] = sum[CW] ? MAXV : sum[CW-1:0];
`ifdef SAT_FLAG_EN
          satNext[c] = sum[CW];
`endif
        end
        OP_SUB, OP_SUBI: begin
          resNext[c*CW +: CW] = (chA < opnd) ? '0 : chA - opnd;
`ifdef SAT_FLAG_EN
          satNext[c] = chA < opnd;
`endif
        end
        OP_MULT, OP_MULTI: begin
          resNext[c*CW +: CW] = (|prod[2*CW-1:CW]) ? MAXV : prod[CW-1:0];
`ifdef SAT_FLAG_EN
          satNext[c] = |prod[2*CW-1:CW];
`endif
        end
        OP_DIV2: resNext[c*CW +: CW] = chA >> 1;
        OP_INV:  resNext[c*CW +: CW] = ~chA;
        OP_AND:  resNext[c*CW +: CW] = chA & chB;
        OP_OR:   resNext[c*CW +: CW] = chA | chB;
        OP_NOR:  resNext[c*CW +: CW] = ~(chA | chB);
        OP_AVG:  resNext[c*CW +: CW] = CW'(s1Sum[c*SW +: SW] / SW'(NPIX));
        default: begin
          resNext[c*CW +: CW] = chA;
          badNext = 1'b1;
        end
      endcase
    end
  end

  // Result registers only load on a real transfer, so back-pressure holds them stable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      bad_op    <= 1'b0;
`ifdef SAT_FLAG_EN
      sat_flag  <= '0;
`endif
    end else if (s1Moves) begin
      out_valid <= s1Full;
      if (s1Full) begin
        result <= resNext;
        bad_op <= badNext;
`ifdef SAT_FLAG_EN
        sat_flag <= satNext;
`endif
      end
    end
  end

endmodule

// File: tb/tb_cell_op_pipeline.sv
// tb/tb_cell_op_pipeline.sv - scoreboard bench for cell_op_pipeline with directed vectors.
module tb_cell_op_pipeline;

  typedef struct packed {
    logic [23:0] res;
    logic        bad;
    logic [2:0]  sat;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   opcode;
  logic [215:0] cell_a;
  logic [215:0] cell_b;
  logic [23:0]  user_input;
  logic         out_valid;
  logic         out_ready;
  logic [23:0]  result;
  logic         bad_op;
`ifdef SAT_FLAG_EN
  logic [2:0]   sat_flag;
`endif

  int   checks = 0;
  int   errors = 0;
  int   inFlight = 0;
  logic prevHeld = 1'b0;
  logic [24:0] prevOut = '0;
  exp_t sb[$];

  cell_op_pipeline dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .opcode     (opcode),
    .cell_a     (cell_a),
    .cell_b     (cell_b),
    .user_input (user_input),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .bad_op     (bad_op)
`ifdef SAT_FLAG_EN
    ,
    .sat_flag   (sat_flag)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, want);
    end
  endtask

  function automatic logic [215:0] mkCell(input logic [23:0] ctr, input logic [23:0] fill,
                                          input logic [23:0] p0);
    logic [215:0] c;
    for (int k = 0; k < 9; k++) c[k*24 +: 24] = fill;
    c[0 +: 24] = p0;
    c[4*24 +: 24] = ctr;
    return c;
  endfunction

  task automatic issue(input logic [3:0] op, input logic [23:0] a, input logic [23:0] b,
                       input logic [23:0] u, input logic [23:0] expRes, input logic expBad,
                       input logic [2:0] expSat);
    int n;
    exp_t e;
    opcode     = op;
    cell_a     = mkCell(a, 24'hAAAAAA, 24'h555555);
    cell_b     = mkCell(b, 24'h333333, 24'hCCCCCC);
    user_input = u;
    in_valid   = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      chk("issue_timeout", 32'd0, 32'd1);
    end else begin
      e.res = expRes;
      e.bad = expBad;
      e.sat = expSat;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 100) begin
      n++;
      @(posedge clk);
      #1;
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      inFlight = 0;
      prevHeld = 1'b0;
    end else begin
      chk("in_ready_model", {31'd0, in_ready}, {31'd0, !(inFlight == 2 && !out_ready)});
      if (prevHeld && out_valid) chk("held_stable", {7'd0, bad_op, result}, {7'd0, prevOut});
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_out", {7'd0, bad_op, result}, 32'hFFFFFFFF);
        end else begin
          e = sb.pop_front();
          chk("result", {8'd0, result}, {8'd0, e.res});
          chk("bad_op", {31'd0, bad_op}, {31'd0, e.bad});
`ifdef SAT_FLAG_EN
          chk("sat_flag", {29'd0, sat_flag}, {29'd0, e.sat});
`endif
        end
      end
      inFlight = inFlight + int'(in_valid && in_ready) - int'(out_valid && out_ready);
      prevHeld = out_valid && !out_ready;
      prevOut  = {bad_op, result};
    end
  end

  logic [3:0]  sOp  [8];
  logic [23:0] sA   [8];
  logic [23:0] sB   [8];
  logic [23:0] sExp [8];
  logic [2:0]  sSat [8];

  initial begin
    sOp[0] = 4'd0; sA[0] = 24'h010203; sB[0] = 24'h102030; sExp[0] = 24'h112233; sSat[0] = 3'b000;
    sOp[1] = 4'd1; sA[1] = 24'h80FF00; sB[1] = 24'h800101; sExp[1] = 24'hFFFF01; sSat[1] = 3'b110;
    sOp[2] = 4'd2; sA[2] = 24'h503010; sB[2] = 24'h104020; sExp[2] = 24'h400000; sSat[2] = 3'b011;
    sOp[3] = 4'd4; sA[3] = 24'h0F0203; sB[3] = 24'h110405; sExp[3] = 24'hFF080F; sSat[3] = 3'b000;
    sOp[4] = 4'd6; sA[4] = 24'hFF0301; sB[4] = 24'h000000; sExp[4] = 24'h7F0100; sSat[4] = 3'b000;
    sOp[5] = 4'd7; sA[5] = 24'h0F00A5; sB[5] = 24'h000000; sExp[5] = 24'hF0FF5A; sSat[5] = 3'b000;
    sOp[6] = 4'd8; sA[6] = 24'hF0F0FF; sB[6] = 24'h3C0F00; sExp[6] = 24'h300000; sSat[6] = 3'b000;
    sOp[7] = 4'd9; sA[7] = 24'hF00F00; sB[7] = 24'h0F0001; sExp[7] = 24'hFF0F01; sSat[7] = 3'b000;

    rst = 1'b0; in_valid = 1'b0; opcode = '0; cell_a = '0; cell_b = '0;
    user_input = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", {8'd0, result}, 32'd0);
    chk("rst_bad_op", {31'd0, bad_op}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // ADD with latency probe: S1 after accept edge, out_valid after the next edge.
    issue(4'd0, 24'hF01080, 24'h200580, 24'h000000, 24'hFF15FF, 1'b0, 3'b101);
    chk("lat_early", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    chk("lat_2cyc", {31'd0, out_valid}, 32'd1);
    drain();

    issue(4'd3, 24'h105000, 24'h777777, 24'h201001, 24'h004000, 1'b0, 3'b101);
    issue(4'd5, 24'h1002FF, 24'h777777, 24'h100301, 24'hFF06FF, 1'b0, 3'b100);
    issue(4'd10, 24'hF00F00, 24'h0F0001, 24'h000000, 24'h00F0FE, 1'b0, 3'b000);
    drain();

    // AVG: every A pixel 09_09_09 except pixel 0 = 00_00_01.
    opcode = 4'd11;
    cell_a = mkCell(24'h090909, 24'h090909, 24'h000001);
    cell_b = '0;
    user_input = 24'hFFFFFF;
    in_valid = 1'b1;
    @(negedge clk);
    chk("avg_ready", {31'd0, in_ready}, 32'd1);
    sb.push_back('{res: 24'h080808, bad: 1'b0, sat: 3'b000});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    drain();

    issue(4'd13, 24'h123456, 24'h111111, 24'h222222, 24'h123456, 1'b1, 3'b000);
    issue(4'd0, 24'h000001, 24'h000001, 24'h000000, 24'h000002, 1'b0, 3'b000);
    drain();

    fork
      begin
        for (int i = 0; i < 8; i++) issue(sOp[i], sA[i], sB[i], sB[i], sExp[i], 1'b0, sSat[i]);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Two instructions in flight, then asynchronous reset mid-cycle.
    out_ready = 1'b0;
    issue(4'd0, 24'h010101, 24'h010101, 24'h0, 24'h020202, 1'b0, 3'b000);
    issue(4'd0, 24'h020202, 24'h020202, 24'h0, 24'h040404, 1'b0, 3'b000);
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_async_valid", {31'd0, out_valid}, 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("post_rst_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    issue(4'd1, 24'h0A0B0C, 24'h0, 24'h010203, 24'h0B0D0F, 1'b0, 3'b000);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
